// File: rtl/ex_muldiv_if.sv
// Handshake/data bundle between the EX stage and the iterative mul/div unit.
// The EX side is the master; the arithmetic unit is the slave.
interface ex_muldiv_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [2:0]        op_i;
  logic [DATA_W-1:0] opdata1_i;
  logic [DATA_W-1:0] opdata2_i;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              annul_i;
  logic              stallreq_o;
  logic              busy_o;
  logic              ready_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              div_by_zero_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, hi_i, lo_i, annul_i,
    input  stallreq_o, busy_o, ready_o, hi_o, lo_o, div_by_zero_o
  );

  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, hi_i, lo_i, annul_i,
    output stallreq_o, busy_o, ready_o, hi_o, lo_o, div_by_zero_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative EX-stage multiply / divide / multiply-accumulate unit writing HI/LO.
// Shift-add multiply (MUL_BITS_CYC bits per cycle) and restoring radix-2 divide.
module ex_muldiv #(
  parameter int DATA_W       = 32,
  parameter int MUL_BITS_CYC = 2
) (
  input logic       clk,
  input logic       rst,
  ex_muldiv_if.slave bus
);
  localparam int W2      = 2 * DATA_W;
  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int MUL_CYC = DATA_W / MUL_BITS_CYC;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              ready_q;
  logic              dbz_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  logic [W2-1:0]     mcand;
  logic [DATA_W-1:0] mplier;
  logic [W2-1:0]     acc;
  logic [W2-1:0]     base;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] dvsr;
  logic              neg_q;
  logic              neg_r;
  logic              is_mac;
  logic              is_sub;

  function automatic logic [W2-1:0] pp_sum(input logic [W2-1:0] m,
                                            input logic [MUL_BITS_CYC-1:0] b);
    logic [W2-1:0] s;
    s = '0;
    for (int i = 0; i < MUL_BITS_CYC; i++)
      if (b[i]) s = s + (m << i);
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(input logic n, input logic [DATA_W-1:0] x);
    return n ? -x : x;
  endfunction

  // Operand decode and magnitude extraction for the cycle the op is accepted
  logic signed [DATA_W-1:0] op1_s;
  logic signed [DATA_W-1:0] op2_s;
  logic                     op_signed;
  logic                     op_is_div;
  logic                     op1_neg;
  logic                     op2_neg;
  logic [DATA_W-1:0]        abs1;
  logic [DATA_W-1:0]        abs2;

  assign op1_s     = bus.opdata1_i;
  assign op2_s     = bus.opdata2_i;
  assign op_signed = ~bus.op_i[0];
  assign op_is_div = (bus.op_i[2:1] == 2'b01);
  assign op1_neg   = op_signed & (op1_s < 0);
  assign op2_neg   = op_signed & (op2_s < 0);
  assign abs1      = cond_neg(op1_neg, bus.opdata1_i);
  assign abs2      = cond_neg(op2_neg, bus.opdata2_i);

  // Next-iteration datapath values and the results they would produce
  logic [W2-1:0]     acc_nxt;
  logic [W2-1:0]     prod;
  logic [W2-1:0]     mul_res;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;

  assign acc_nxt = acc + pp_sum(mcand, mplier[MUL_BITS_CYC-1:0]);
  assign prod    = neg_q ? -acc_nxt : acc_nxt;
  assign mul_res = !is_mac ? prod : (is_sub ? base - prod : base + prod);
  assign shifted = {rem, quo[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvsr};
  assign rem_nxt = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_nxt = {quo[DATA_W-2:0], ~diff[DATA_W]};

  // Datapath registers: loaded while idle, iterated in MUL/DIV, no reset needed
  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      mcand  <= {{DATA_W{1'b0}}, abs1};
      mplier <= abs2;
      acc    <= '0;
      base   <= {bus.hi_i, bus.lo_i};
      rem    <= '0;
      quo    <= abs1;
      dvsr   <= abs2;
      neg_q  <= op1_neg ^ op2_neg;
      neg_r  <= op1_neg;
      is_mac <= bus.op_i[2];
      is_sub <= bus.op_i[2] & bus.op_i[1];
    end else if (state == S_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << MUL_BITS_CYC;
      mplier <= mplier >> MUL_BITS_CYC;
    end else if (state == S_DIV) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

  // Control FSM with registered result/handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      ready_q <= 1'b0;
      if (bus.annul_i) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start_i) begin
              if (!op_is_div) begin
                state <= S_MUL;
                cnt   <= CNT_W'(MUL_CYC);
              end else if (bus.opdata2_i == '0) begin
                state   <= S_DONE;
                ready_q <= 1'b1;
                dbz_q   <= 1'b1;
                hi_q    <= '0;
                lo_q    <= '0;
              end else begin
                state <= S_DIV;
                cnt   <= CNT_W'(DATA_W);
              end
            end
          end
          S_MUL: begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state         <= S_DONE;
              ready_q       <= 1'b1;
              dbz_q         <= 1'b0;
              {hi_q, lo_q}  <= mul_res;
            end
          end
          S_DIV: begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state   <= S_DONE;
              ready_q <= 1'b1;
              dbz_q   <= 1'b0;
              hi_q    <= cond_neg(neg_r, rem_nxt);
              lo_q    <= cond_neg(neg_q, quo_nxt);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.stallreq_o    = ((state == S_IDLE) & bus.start_i & ~bus.annul_i)
                           | (state == S_MUL) | (state == S_DIV);
  assign bus.busy_o        = (state != S_IDLE);
  assign bus.ready_o       = ready_q;
  assign bus.div_by_zero_o = dbz_q;
  assign bus.hi_o          = hi_q;
  assign bus.lo_o          = lo_q;
endmodule
